ld650_dac_sequencer: RTL and testbench
======================================

# ld650_dac_sequencer

Setpoint sequencer for the two LD650 laser-diode current channels, directly upstream of the dual-channel serial DAC writer. Accepts target current codes from the control plane and steps each channel's DAC code toward its target in bounded increments, one DAC write at a time. It issues single-cycle start pulses, waits for the writer's finish flag, round-robins between channels, and forwards laser-off requests. After power-up and after every laser-off, it waits out the writer's two-write initialisation sequence.

## Interface
- STEP, 12'd16, max code change per write (ramp mode)
- DWELL, 16'd1000, clk cycles between a write finishing and the next start (min effective 1)
- TIMEOUT, 12'd1024, clk cycles to wait for finish before abandoning a write
- clk  in  1  main clock
- Reset  in  1  reset; asynchronous, active-low
- ch1_target  in  12  channel-1 target code, sampled when ch1_target_valid=1
- ch1_target_valid  in  1  one-cycle load strobe
- ch2_target  in  12  channel-2 target code
- ch2_target_valid  in  1  one-cycle load strobe
- laser_off_req  in  1  one-cycle request: drive both channels to 0 via writer re-init
- DAWrFinishFlag  in  1  one-cycle pulse from writer at end of each write
- LD650_1DACStartFlag  out  1  one-cycle write request, channel 1
- LD650_2DACStartFlag  out  1  one-cycle write request, channel 2
- LD650_1DACData  out  12  channel-1 code, held stable from start until finish
- LD650_2DACData  out  12  channel-2 code, held stable from start until finish
- LD650_1LaserOffFlag  out  1  one-cycle laser-off pulse to writer
- ch1_cur, ch2_cur  out  12 each  last code confirmed written
- busy  out  1  state≠IDLE or any cur≠target
- timeout_err  out  1  sticky; set on write timeout

## Operation
- All outputs reset to 0. Internal targets reset to 0. State resets to INIT with init_cnt=0.
- INIT: count DAWrFinishFlag pulses. On the 2nd pulse, go to DWELL (init_cnt cleared).
- IDLE: evaluated every cycle, in this priority order:
  - off_pend → OFF.
  - Else select a channel with cur≠target. Round-robin: the channel after the last served; ch1 first after reset. Go to ISSUE.
  - Else stay in IDLE.
- ISSUE (1 cycle):
  - Compute next code for the selected channel:
    - If target>cur: cur+min(STEP, target−cur).
    - Else: cur−min(STEP, cur−target).
  - Compute in 13-bit unsigned; no wrap below 0 or above 4095.
  - Register the next code onto that channel's DACData output and pulse its StartFlag on the same edge. Go to WAIT.
- WAIT: count cycles.
  - On DAWrFinishFlag: commit the next code to cur, go to DWELL.
  - When the count reaches TIMEOUT: set timeout_err, leave cur unchanged, go to DWELL. The write is retried on the next selection.
- DWELL: count max(DWELL,1) cycles, then go to IDLE.
- OFF (1 cycle): pulse LD650_1LaserOffFlag, clear both targets, both cur, both DACData, and off_pend. Go to INIT.
- laser_off_req sets off_pend in any state. It is acted on only from IDLE, so an in-flight write always completes or times out first.
- target_valid loads the internal target in any state. It takes effect at the next IDLE selection and never alters DACData while a write is in flight.
- Same cycle as laser_off_req: target_valid is discarded, because off wins.
- timeout_err clears on laser_off_req or reset.
- Reset mid-write: everything returns to reset values; INIT then waits for the writer's own re-init.

## Timing
- StartFlag width is exactly 1 cycle. At most one StartFlag is high per cycle.
- Start of a new write comes ≥1+DWELL cycles after the finish pulse.
- DACData changes only on the ISSUE edge, coincident with its StartFlag rise.
- Latency from IDLE with a pending delta to StartFlag: 2 edges (select, issue).
- cur updates on the edge after DAWrFinishFlag is sampled.
- Writes needed for a full ramp: ceil(|target−cur|/STEP).

## Configuration
- LD650_RAMP_EN defined: stepped ramping as above.
- LD650_RAMP_EN undefined: next code = target (single write per change); STEP ignored; all other behaviour identical.

## Test plan
- Reset, then 2 finish pulses → no StartFlag before the 2nd finish; IDLE after DWELL; busy=0 with targets 0.
- ch1_target=0x040, STEP=16, writer model finishing 50 cycles after start → 4 starts with data 0x010, 0x020, 0x030, 0x040; gaps ≥DWELL; ch1_cur=0x040.
- ch1=0x020 and ch2=0x020 loaded together → starts alternate ch1, ch2, ch1, ch2; final cur both 0x020.
- laser_off_req mid-WAIT → write finishes, one LaserOffFlag pulse, cur/targets/data=0, no start until 2 more finishes.
- No finish pulse from writer → timeout_err=1 after 1024 cycles; retry with the same data; laser_off_req clears timeout_err.
- LD650_RAMP_EN undefined, ch2_target=0xABC → single start, LD650_2DACData=0xABC.

Source files
------------

// File: rtl/ld650_dac_sequencer.sv
// ---------------------------------------------------------------------------
// ld650_dac_sequencer
//
// Setpoint sequencer for the two LD650 laser-diode current channels. It sits
// directly upstream of the dual-channel serial DAC writer. Each channel's DAC
// code is moved toward its target one write at a time. Channels are served
// round-robin, and laser-off requests are forwarded to the writer. After
// power-up and after every laser-off, the sequencer waits out the writer's
// two-write initialisation sequence.
//
// Build option:
//   LD650_RAMP_EN  defined   : each write moves the code at most STEP
//                  undefined : each write jumps straight to the target
//
// Parameters:
//   STEP     max code change per write (ramp build only)
//   DWELL    cycles between a write finishing and the next start (min 1)
//   TIMEOUT  cycles to wait for the writer's finish before giving up
//
// Ports:
//   clk, Reset            clock; asynchronous active-low reset
//   ch1_target(_valid)    channel-1 target code and one-cycle load strobe
//   ch2_target(_valid)    channel-2 target code and one-cycle load strobe
//   laser_off_req         one-cycle request to drive both channels to 0
//   DAWrFinishFlag        one-cycle pulse from the writer at end of a write
//   LD650_1/2DACStartFlag one-cycle write request per channel
//   LD650_1/2DACData      channel code, held from start until finish
//   LD650_1LaserOffFlag   one-cycle laser-off pulse to the writer
//   ch1_cur, ch2_cur      last code confirmed written
//   busy                  not idle, or some channel not at its target
//   timeout_err           sticky write-timeout flag
// ---------------------------------------------------------------------------
module ld650_dac_sequencer #(
  parameter logic [11:0] STEP    = 12'd16,
  parameter logic [15:0] DWELL   = 16'd1000,
  parameter logic [11:0] TIMEOUT = 12'd1024
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [11:0] ch1_target,
  input  logic        ch1_target_valid,
  input  logic [11:0] ch2_target,
  input  logic        ch2_target_valid,
  input  logic        laser_off_req,
  input  logic        DAWrFinishFlag,
  output logic        LD650_1DACStartFlag,
  output logic        LD650_2DACStartFlag,
  output logic [11:0] LD650_1DACData,
  output logic [11:0] LD650_2DACData,
  output logic        LD650_1LaserOffFlag,
  output logic [11:0] ch1_cur,
  output logic [11:0] ch2_cur,
  output logic        busy,
  output logic        timeout_err
);

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DWELL = 3'd4;
  localparam logic [2:0] ST_OFF   = 3'd5;

  // A DWELL of 0 still spends one cycle in the dwell state.
  localparam logic [15:0] DWELL_LAST   = (DWELL == 16'd0) ? 16'd0 : DWELL - 16'd1;
  localparam logic [15:0] TIMEOUT_LAST = {4'd0, TIMEOUT} - 16'd1;

  logic [2:0]  state_q, state_d;
  logic        init_cnt_q, init_cnt_d;   // writer finishes seen during INIT
  logic [15:0] cnt_q, cnt_d;             // shared WAIT / DWELL cycle counter
  logic        sel_q, sel_d;             // channel being written: 0=ch1, 1=ch2
  logic        last_q, last_d;           // channel served most recently
  logic [11:0] tgt1_q, tgt1_d, tgt2_q, tgt2_d;
  logic [11:0] cur1_q, cur1_d, cur2_q, cur2_d;
  logic [11:0] data1_q, data1_d, data2_q, data2_d;
  logic        start1_q, start1_d, start2_q, start2_d;
  logic        off_flag_q, off_flag_d;
  logic        off_pend_q, off_pend_d;
  logic        terr_q, terr_d;

  logic        pend1, pend2, pick;
  logic [11:0] sel_cur, sel_tgt, next_code;

  assign pend1   = (cur1_q != tgt1_q);
  assign pend2   = (cur2_q != tgt2_q);
  // With both channels pending, serve the one not served last time.
  assign pick    = (pend1 && pend2) ? ~last_q : pend2;
  assign sel_cur = sel_q ? cur2_q : cur1_q;
  assign sel_tgt = sel_q ? tgt2_q : tgt1_q;

`ifdef LD650_RAMP_EN
  // 13-bit arithmetic so the step can never wrap past 0 or 4095.
  logic [12:0] diff13, step13, next13;

  always_comb begin
    diff13 = 13'd0;
    step13 = 13'd0;
    next13 = {1'b0, sel_cur};
    if (sel_tgt > sel_cur) begin
      diff13 = {1'b0, sel_tgt} - {1'b0, sel_cur};
      step13 = (diff13 > {1'b0, STEP}) ? {1'b0, STEP} : diff13;
      next13 = {1'b0, sel_cur} + step13;
    end else begin
      diff13 = {1'b0, sel_cur} - {1'b0, sel_tgt};
      step13 = (diff13 > {1'b0, STEP}) ? {1'b0, STEP} : diff13;
      next13 = {1'b0, sel_cur} - step13;
    end
  end

  assign next_code = next13[11:0];
`else
  // Without ramping the code jumps straight to the target, so STEP and the
  // current code play no part in the next value.
  logic unused_no_ramp;
  assign unused_no_ramp = ^{STEP, sel_cur};
  assign next_code      = sel_tgt;
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    last_d     = last_q;
    tgt1_d     = tgt1_q;
    tgt2_d     = tgt2_q;
    cur1_d     = cur1_q;
    cur2_d     = cur2_q;
    data1_d    = data1_q;
    data2_d    = data2_q;
    start1_d   = 1'b0;
    start2_d   = 1'b0;
    off_flag_d = 1'b0;
    off_pend_d = off_pend_q;
    terr_d     = terr_q;

    case (state_q)
      ST_INIT: begin
        if (DAWrFinishFlag) begin
          if (init_cnt_q) begin
            init_cnt_d = 1'b0;
            cnt_d      = 16'd0;
            state_d    = ST_DWELL;
          end else begin
            init_cnt_d = 1'b1;
          end
        end
      end

      ST_IDLE: begin
        if (off_pend_q) begin
          off_flag_d = 1'b1;
          state_d    = ST_OFF;
        end else if (pend1 || pend2) begin
          sel_d   = pick;
          last_d  = pick;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // Data and start flag leave on the same edge; data then holds
        // until the next ISSUE (or laser-off).
        if (sel_q) begin
          data2_d  = next_code;
          start2_d = 1'b1;
        end else begin
          data1_d  = next_code;
          start1_d = 1'b1;
        end
        cnt_d   = 16'd0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (DAWrFinishFlag) begin
          if (sel_q) cur2_d = data2_q;
          else       cur1_d = data1_q;
          cnt_d   = 16'd0;
          state_d = ST_DWELL;
        end else if (cnt_q == TIMEOUT_LAST) begin
          // Abandon the write; cur stays put so the channel is reselected.
          terr_d  = 1'b1;
          cnt_d   = 16'd0;
          state_d = ST_DWELL;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_DWELL: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d   = 16'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_OFF: begin
        tgt1_d     = 12'd0;
        tgt2_d     = 12'd0;
        cur1_d     = 12'd0;
        cur2_d     = 12'd0;
        data1_d    = 12'd0;
        data2_d    = 12'd0;
        off_pend_d = 1'b0;
        init_cnt_d = 1'b0;
        state_d    = ST_INIT;
      end

      default: state_d = ST_INIT;
    endcase

    // Control-plane requests are accepted in every state. A laser-off in the
    // same cycle as a target load discards the load.
    if (laser_off_req) begin
      off_pend_d = 1'b1;
      terr_d     = 1'b0;
    end else begin
      if (ch1_target_valid) tgt1_d = ch1_target;
      if (ch2_target_valid) tgt2_d = ch2_target;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= 1'b0;
      cnt_q      <= 16'd0;
      sel_q      <= 1'b0;
      last_q     <= 1'b1;   // "last served ch2" makes ch1 go first
      tgt1_q     <= 12'd0;
      tgt2_q     <= 12'd0;
      cur1_q     <= 12'd0;
      cur2_q     <= 12'd0;
      data1_q    <= 12'd0;
      data2_q    <= 12'd0;
      start1_q   <= 1'b0;
      start2_q   <= 1'b0;
      off_flag_q <= 1'b0;
      off_pend_q <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      tgt1_q     <= tgt1_d;
      tgt2_q     <= tgt2_d;
      cur1_q     <= cur1_d;
      cur2_q     <= cur2_d;
      data1_q    <= data1_d;
      data2_q    <= data2_d;
      start1_q   <= start1_d;
      start2_q   <= start2_d;
      off_flag_q <= off_flag_d;
      off_pend_q <= off_pend_d;
      terr_q     <= terr_d;
    end
  end

  assign LD650_1DACStartFlag = start1_q;
  assign LD650_2DACStartFlag = start2_q;
  assign LD650_1DACData      = data1_q;
  assign LD650_2DACData      = data2_q;
  assign LD650_1LaserOffFlag = off_flag_q;
  assign ch1_cur             = cur1_q;
  assign ch2_cur             = cur2_q;
  assign timeout_err         = terr_q;
  assign busy                = (state_q != ST_IDLE) || pend1 || pend2;

endmodule

// File: tb/tb_ld650_dac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ld650_dac_sequencer
//
// Directed bench for ld650_dac_sequencer with default parameters (STEP=16,
// DWELL=1000, TIMEOUT=1024). Expected codes follow LD650_RAMP_EN: stepped
// values when it is defined, direct jumps to the target otherwise.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ld650_dac_sequencer;

  localparam int DW = 1000;
  localparam int TO = 1024;

  logic        clk = 1'b0;
  logic        Reset;
  logic [11:0] ch1_target, ch2_target;
  logic        ch1_target_valid, ch2_target_valid;
  logic        laser_off_req, DAWrFinishFlag;
  logic        LD650_1DACStartFlag, LD650_2DACStartFlag;
  logic [11:0] LD650_1DACData, LD650_2DACData;
  logic        LD650_1LaserOffFlag;
  logic [11:0] ch1_cur, ch2_cur;
  logic        busy, timeout_err;

  ld650_dac_sequencer #(
    .STEP   (12'd16),
    .DWELL  (16'd1000),
    .TIMEOUT(12'd1024)
  ) dut (
    .clk                (clk),
    .Reset              (Reset),
    .ch1_target         (ch1_target),
    .ch1_target_valid   (ch1_target_valid),
    .ch2_target         (ch2_target),
    .ch2_target_valid   (ch2_target_valid),
    .laser_off_req      (laser_off_req),
    .DAWrFinishFlag     (DAWrFinishFlag),
    .LD650_1DACStartFlag(LD650_1DACStartFlag),
    .LD650_2DACStartFlag(LD650_2DACStartFlag),
    .LD650_1DACData     (LD650_1DACData),
    .LD650_2DACData     (LD650_2DACData),
    .LD650_1LaserOffFlag(LD650_1LaserOffFlag),
    .ch1_cur            (ch1_cur),
    .ch2_cur            (ch2_cur),
    .busy               (busy),
    .timeout_err        (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Running observations of pulse outputs.
  int starts1 = 0, starts2 = 0, offs = 0;
  bit multi_seen = 1'b0, wide_seen = 1'b0;
  bit prev1 = 1'b0, prev2 = 1'b0;

  always @(negedge clk) begin
    if (LD650_1DACStartFlag) starts1++;
    if (LD650_2DACStartFlag) starts2++;
    if (LD650_1LaserOffFlag) offs++;
    if (LD650_1DACStartFlag && LD650_2DACStartFlag) multi_seen = 1'b1;
    if ((LD650_1DACStartFlag && prev1) || (LD650_2DACStartFlag && prev2)) wide_seen = 1'b1;
    prev1 = LD650_1DACStartFlag;
    prev2 = LD650_2DACStartFlag;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic finish_pulse();
    DAWrFinishFlag = 1'b1;
    @(negedge clk);
    DAWrFinishFlag = 1'b0;
  endtask

  task automatic load(input int ch, input logic [11:0] val);
    if (ch == 1) begin ch1_target = val; ch1_target_valid = 1'b1; end
    else         begin ch2_target = val; ch2_target_valid = 1'b1; end
    @(negedge clk);
    ch1_target_valid = 1'b0;
    ch2_target_valid = 1'b0;
  endtask

  // Waits up to budget cycles for a start pulse; ch=0 if none arrived.
  task automatic wait_start(input int budget, output int ch,
                            output logic [11:0] data, output int waited);
    ch = 0; data = 12'd0; waited = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (LD650_1DACStartFlag) begin ch = 1; data = LD650_1DACData; waited = i; break; end
      if (LD650_2DACStartFlag) begin ch = 2; data = LD650_2DACData; waited = i; break; end
    end
  endtask

  task automatic wait_off(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (LD650_1LaserOffFlag) begin seen = 1'b1; break; end
    end
  endtask

  // One write served by a writer that finishes 50 cycles after start.
  task automatic do_write(input string tag, input int exp_ch,
                          input logic [11:0] exp_data, input bit gap_chk);
    int ch, waited;
    logic [11:0] data;
    wait_start(DW + 100, ch, data, waited);
    check({tag, "_ch"}, ch, exp_ch);
    check({tag, "_data"}, data, exp_data);
    if (gap_chk) check({tag, "_gap"}, waited >= DW + 1, 1);
    tick(49);
    check({tag, "_hold"}, (exp_ch == 2) ? LD650_2DACData : LD650_1DACData, exp_data);
    finish_pulse();
  endtask

  initial begin
    int ch, waited, base;
    logic [11:0] data;
    bit seen;

    Reset = 1'b0;
    ch1_target = 12'd0; ch2_target = 12'd0;
    ch1_target_valid = 1'b0; ch2_target_valid = 1'b0;
    laser_off_req = 1'b0; DAWrFinishFlag = 1'b0;

    // ---- reset values
    tick(3);
    check("rst_start1", LD650_1DACStartFlag, 0);
    check("rst_start2", LD650_2DACStartFlag, 0);
    check("rst_data1", LD650_1DACData, 0);
    check("rst_data2", LD650_2DACData, 0);
    check("rst_off", LD650_1LaserOffFlag, 0);
    check("rst_cur1", ch1_cur, 0);
    check("rst_cur2", ch2_cur, 0);
    check("rst_terr", timeout_err, 0);
    Reset = 1'b1;

    // ---- writer init: no start before the 2nd finish, idle after dwell
    tick(20);
    check("init_busy", busy, 1);
    finish_pulse();
    tick(10);
    check("init_no_start_a", starts1 + starts2, 0);
    finish_pulse();
    tick(DW + 5);
    check("init_idle_busy", busy, 0);
    check("init_no_start_b", starts1 + starts2, 0);

    // ---- both channels loaded together: round-robin from ch1
    ch1_target = 12'h020; ch2_target = 12'h020;
    ch1_target_valid = 1'b1; ch2_target_valid = 1'b1;
    tick(1);
    ch1_target_valid = 1'b0; ch2_target_valid = 1'b0;
    tick(1);
    check("alt_busy", busy, 1);
`ifdef LD650_RAMP_EN
    do_write("alt1", 1, 12'h010, 1'b0);
    do_write("alt2", 2, 12'h010, 1'b1);
    do_write("alt3", 1, 12'h020, 1'b1);
    do_write("alt4", 2, 12'h020, 1'b1);
`else
    do_write("alt1", 1, 12'h020, 1'b0);
    do_write("alt2", 2, 12'h020, 1'b1);
`endif
    tick(3);
    check("alt_cur1", ch1_cur, 12'h020);
    check("alt_cur2", ch2_cur, 12'h020);
    tick(DW + 5);
    check("alt_idle_busy", busy, 0);

    // ---- laser-off requested while a write is in flight
    load(1, 12'h100);
    wait_start(20, ch, data, waited);
    check("off_wr_ch", ch, 1);
`ifdef LD650_RAMP_EN
    check("off_wr_data", data, 12'h030);
`else
    check("off_wr_data", data, 12'h100);
`endif
    tick(10);
    laser_off_req = 1'b1;
    tick(1);
    laser_off_req = 1'b0;
    tick(20);
    check("off_waits_for_write", offs, 0);
    tick(18);
    finish_pulse();
    tick(2);
`ifdef LD650_RAMP_EN
    check("off_write_committed", ch1_cur, 12'h030);
`else
    check("off_write_committed", ch1_cur, 12'h100);
`endif
    wait_off(DW + 20, seen);
    check("off_pulse_seen", seen, 1);
    tick(1);
    check("off_count", offs, 1);
    check("off_cur1", ch1_cur, 0);
    check("off_cur2", ch2_cur, 0);
    check("off_data1", LD650_1DACData, 0);
    check("off_data2", LD650_2DACData, 0);
    check("off_reinit_busy", busy, 1);

    // ---- new target during re-init: nothing starts until 2 finishes
    base = starts1 + starts2;
    load(1, 12'h040);
    tick(100);
    finish_pulse();
    tick(100);
    check("reinit_no_start", starts1 + starts2, base);
    finish_pulse();
`ifdef LD650_RAMP_EN
    do_write("ramp1", 1, 12'h010, 1'b1);
    do_write("ramp2", 1, 12'h020, 1'b1);
    do_write("ramp3", 1, 12'h030, 1'b1);
    do_write("ramp4", 1, 12'h040, 1'b1);
`else
    do_write("ramp1", 1, 12'h040, 1'b1);
`endif
    tick(3);
    check("ramp_cur1", ch1_cur, 12'h040);
    check("ramp_cur2", ch2_cur, 0);

    // ---- writer never finishes: timeout, then retry with the same data
    load(2, 12'hABC);
    wait_start(DW + 100, ch, data, waited);
    check("to_ch", ch, 2);
`ifdef LD650_RAMP_EN
    check("to_data", data, 12'h010);
`else
    check("to_data", data, 12'hABC);
`endif
    tick(1000);
    check("to_not_yet", timeout_err, 0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (timeout_err) begin seen = 1'b1; break; end
    end
    check("to_set", seen, 1);
    check("to_cur2_kept", ch2_cur, 0);
`ifdef LD650_RAMP_EN
    do_write("retry", 2, 12'h010, 1'b1);
    tick(3);
    check("retry_cur2", ch2_cur, 12'h010);
`else
    do_write("retry", 2, 12'hABC, 1'b1);
    tick(3);
    check("retry_cur2", ch2_cur, 12'hABC);
`endif
    check("to_sticky", timeout_err, 1);
    laser_off_req = 1'b1;
    tick(1);
    laser_off_req = 1'b0;
    check("to_cleared", timeout_err, 0);
    wait_off(DW + 20, seen);
    check("off2_pulse_seen", seen, 1);
    tick(1);
    check("off2_count", offs, 2);
    check("off2_cur2", ch2_cur, 0);
    check("off2_data2", LD650_2DACData, 0);
    finish_pulse();
    tick(5);
    finish_pulse();
    tick(DW + 5);
    check("final_idle_busy", busy, 0);

    // ---- pulse-shape bookkeeping over the whole run
`ifdef LD650_RAMP_EN
    check("total_starts1", starts1, 7);
    check("total_starts2", starts2, 4);
`else
    check("total_starts1", starts1, 3);
    check("total_starts2", starts2, 3);
`endif
    check("one_start_per_cycle", multi_seen, 0);
    check("start_width_1", wide_seen, 0);
    check("total_offs", offs, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
